// File: rtl/pulse_scheduler_pkg.sv
// Shared definitions for the pulse scheduler: FSM state encoding and default widths.
package pulse_pkg;

  localparam int W_DEF  = 8;
  localparam int NW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } pulse_state_t;

endpackage

// File: rtl/pulse_scheduler_if.sv
// Request/config and pulse-output bundle of the pulse scheduler, plus its debug state.
// Handshake: req is a level request sampled only in IDLE; grant answers it one cycle later
// and stays asserted through FIN; done pulses once per finished sequence.
interface pulse_scheduler_if #(
  parameter int W  = 8,
  parameter int NW = 4
);
  import pulse_pkg::*;

  logic [1:0]    req;
  logic [W-1:0]  cfg_high0;
  logic [W-1:0]  cfg_low0;
  logic [NW-1:0] cfg_n0;
  logic [W-1:0]  cfg_high1;
  logic [W-1:0]  cfg_low1;
  logic [NW-1:0] cfg_n1;
  logic [1:0]    grant;
  logic          busy;
  logic          signal;
  logic          done;
  logic          done_id;
  pulse_state_t  state;

  modport master (
    output req, cfg_high0, cfg_low0, cfg_n0, cfg_high1, cfg_low1, cfg_n1,
    input  grant, busy, signal, done, done_id, state
  );

  modport slave (
    input  req, cfg_high0, cfg_low0, cfg_n0, cfg_high1, cfg_low1, cfg_n1,
    output grant, busy, signal, done, done_id, state
  );

endinterface

// File: rtl/pulse_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not own last wins.
module pulse_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win,
  output logic       win_idx
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_owner ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    win_idx = win[1];
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one pulse-train generator between two requesters; latches the winner's
// high/low/count config and plays it out as HIGH/LOW phases followed by a one-cycle FIN.
module pulse_scheduler
  import pulse_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input logic               clock,
  input logic               reset,
  pulse_scheduler_if.slave  bus
);

  localparam logic [W-1:0]  ONE_W = 1;
  localparam logic [NW-1:0] ONE_N = 1;

  pulse_state_t  state, state_next;
  logic [W-1:0]  high_q, low_q, phase_cnt;
  logic [NW-1:0] pulse_cnt;
  logic          owner, last_owner;
  logic [1:0]    win;
  logic          win_idx;
  logic [W-1:0]  sel_high, sel_low;
  logic [NW-1:0] sel_n;
  logic          any_win, phase_last, pulse_last;

  pulse_rr_arb2 u_arb (
    .req        (bus.req),
    .last_owner (last_owner),
    .win        (win),
    .win_idx    (win_idx)
  );

  // Winner's config with zero widths already promoted to one cycle.
  always_comb begin
    sel_high = win_idx ? bus.cfg_high1 : bus.cfg_high0;
    sel_low  = win_idx ? bus.cfg_low1  : bus.cfg_low0;
    sel_n    = win_idx ? bus.cfg_n1    : bus.cfg_n0;
    if (sel_high == '0) sel_high = ONE_W;
    if (sel_low  == '0) sel_low  = ONE_W;
  end

  assign any_win    = (win != 2'b00);
  assign phase_last = (phase_cnt == ONE_W);
  assign pulse_last = (pulse_cnt == ONE_N);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_win) state_next = (sel_n == '0) ? FIN : HIGH;
      HIGH: if (phase_last) state_next = LOW;
      LOW:  if (phase_last) state_next = pulse_last ? FIN : HIGH;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config latch and counters; every phase entry reloads from the latched widths.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_q     <= '0;
      low_q      <= '0;
      phase_cnt  <= '0;
      pulse_cnt  <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_win) begin
            high_q     <= sel_high;
            low_q      <= sel_low;
            phase_cnt  <= sel_high;
            pulse_cnt  <= sel_n;
            owner      <= win_idx;
            last_owner <= win_idx;
          end
        end
        HIGH: begin
          if (phase_last) phase_cnt <= low_q;
          else            phase_cnt <= phase_cnt - ONE_W;
        end
        LOW: begin
          if (phase_last) begin
            phase_cnt <= high_q;
            pulse_cnt <= pulse_cnt - ONE_N;
          end else begin
            phase_cnt <= phase_cnt - ONE_W;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.state   = state;
    bus.busy    = (state != IDLE);
    bus.grant   = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    bus.signal  = (state == HIGH);
    bus.done    = (state == FIN);
    bus.done_id = (state == FIN) ? owner : 1'b0;
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Shares one programmable pulse-train generator between two requesters, with round-robin arbitration.
- Each requester supplies its own high width, low width and pulse count.
- The winner's configuration is latched. The block then emits exactly that pulse train on `signal` and flags completion.
- Sits between the clock source and any consumers of timed pulse patterns, replacing free-running pulse generators.

Parameters:
- W, 8: width of the high/low phase length fields, in clock cycles.
- NW, 4: width of the pulse-count field.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  level request, bit i = requester i.
- cfg_high0  in  W  requester 0 high-phase length, in cycles.
- cfg_low0  in  W  requester 0 low-phase length, in cycles.
- cfg_n0  in  NW  requester 0 pulse count.
- cfg_high1  in  W  requester 1 high-phase length, in cycles.
- cfg_low1  in  W  requester 1 low-phase length, in cycles.
- cfg_n1  in  NW  requester 1 pulse count.
- grant  out  2  one-hot owner of the generator; 00 when idle.
- busy  out  1  1 while state is not IDLE.
- signal  out  1  generated pulse train.
- done  out  1  one-cycle completion strobe.
- done_id  out  1  requester index that finished; valid only while done=1.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-sequence):
  - state=IDLE; grant=00; busy=0; signal=0; done=0; done_id=0.
  - Counters are cleared.
  - last_owner=1, so requester 0 wins first after reset.
- All outputs are registered.
- States: IDLE, HIGH, LOW, FIN.
- IDLE:
  - If req==00, stay in IDLE.
  - Otherwise pick the winner:
    - If only one bit is set, that requester wins.
    - If both are set, the requester not equal to last_owner wins.
  - Latch the winner's cfg_high, cfg_low and cfg_n into internal registers; set grant and last_owner.
  - Next state:
    - HIGH if the latched n is nonzero.
    - FIN if n==0, which holds grant for exactly one cycle and emits no pulse.
- Latency: req sampled in IDLE at edge k → from edge k+1: grant valid, busy=1, and signal=1 when n is nonzero.
- HIGH:
  - signal=1 for max(cfg_high,1) cycles; a zero width is treated as 1.
  - Then go to LOW.
- LOW:
  - signal=0 for max(cfg_low,1) cycles.
  - Then decrement the remaining count.
  - Go to HIGH if pulses remain, else go to FIN.
  - The final low phase is always emitted in full.
- FIN:
  - Lasts one cycle: done=1, done_id=owner, signal=0, grant still asserted.
  - Next state is IDLE, where grant clears.
- Minimum gap between sequences: FIN cycle + IDLE cycle, so 2 cycles of signal=0 before the next grant's first HIGH.
- Total cycles per sequence: n*(h'+l') + 1 (FIN), where h' and l' are the widths after zero→1 substitution.
- Config inputs and req changes during a sequence are ignored.
  - Dropping req mid-sequence does not abort.
  - A held req is re-arbitrated only in IDLE.
- Phase counters are W bits and count down from the latched width; the pulse counter is NW bits. No wrap-around: counters reload from the latched values on every phase entry.
- Maximum values (h=l=2^W−1, n=2^NW−1) must complete without overflow.

Decomposition:
- Shared package (pulse_pkg): state encoding constants IDLE=2'd0, HIGH=2'd1, LOW=2'd2, FIN=2'd3, plus default W/NW constants.
- One sub-module: pulse_rr_arb2, the 2-input round-robin arbiter.
  - Inputs: req, last_owner.
  - Outputs: one-hot win and its index.
  - Purely combinational.
- The FSM, config latch and counters stay in pulse_scheduler.

Test Plan:
- Single requester with the 4/4 pattern:
  - Stimulus: reset, then req=01, cfg_high0=4, cfg_low0=4, cfg_n0=3.
  - Required: grant=01 from the next edge. signal is 1111 0000 repeated 3 times (24 cycles), then FIN with done=1, done_id=0, then grant=00.
- Simultaneous requests, two rounds:
  - Stimulus: req=11 with requester 0 config h=2,l=1,n=1 and requester 1 config h=1,l=1,n=2.
  - Required: requester 0 served first (signal 110). After FIN+IDLE, requester 1 is served (signal 1010) with done_id=1.
  - Then re-issue req=11; requester 0 wins again (last_owner=1).
- Zero-case handling:
  - Stimulus: requester 0 with cfg_n0=0.
  - Required: grant=01 for one cycle, done=1 in the same cycle, signal stays 0.
  - Stimulus: h=0, l=0, n=2.
  - Required: signal 1010, i.e. zero widths treated as 1.
- Reset mid-operation:
  - Stimulus: assert reset during the second HIGH phase of an n=3 sequence.
  - Required: at the next edge, all outputs are 0 and state is IDLE, with no done strobe. A held req=01 is re-granted one cycle after reset deasserts.
- Ignored changes mid-sequence:
  - Stimulus: during a sequence, change cfg_high0 and drop req.
  - Required: the pulse train matches the latched values exactly and done still fires.
- Maximum-value stress:
  - Stimulus: W=8, NW=4 with h=l=255, n=15.
  - Required: exactly 15*510+1 cycles with busy=1, and the high-cycle count is 3825.
